seq_alu: RTL and testbench

Multi-cycle, width-parametrised ALU that replaces the combinational datapath ALU. It accepts one operation per start/done handshake from the control unit. Single-cycle operations complete in one clock. Multiply (shift-add) and divide (restoring) iterate one bit per clock, so no wide combinational array is needed. It drives a registered 2×WIDTH result into the Z register path: HI = upper half, LO = lower half.

---
 rtl/seq_alu_if.sv | 25 ++
 rtl/seq_alu.sv | 248 ++++++++++++++++++++++++
 tb/tb_seq_alu.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_alu_if.sv
// seq_alu request/result bundle between the control unit and the ALU.
// master = control unit, slave = ALU.
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic [4:0]           opcode;
  logic [WIDTH-1:0]     ra;
  logic [WIDTH-1:0]     rb;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   result;
  logic                 div0;
  logic                 illegal;

  modport master (
    output start, opcode, ra, rb,
    input  busy, done, result, div0, illegal
  );

  modport slave (
    input  start, opcode, ra, rb,
    output busy, done, result, div0, illegal
  );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU: one-cycle ops, shift-add multiply, restoring divide.
// Define SEQ_ALU_SIGNED_EN for two's-complement mul/div with a FIX stage.
module seq_alu #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input logic      clk,
  input logic      clr,
  seq_alu_if.slave bus
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] EXEC = 3'd1;
  localparam logic [2:0] MUL  = 3'd2;
  localparam logic [2:0] DIV  = 3'd3;
  localparam logic [2:0] FIX  = 3'd4;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;

  localparam logic [SHW:0] LAST = (SHW+1)'(WIDTH - 1);
  localparam logic [SHW:0] ONE  = (SHW+1)'(1);

`ifdef SEQ_ALU_SIGNED_EN
  localparam logic SGN = 1'b1;
`else
  localparam logic SGN = 1'b0;
`endif

  logic [2:0]         state_q, state_d;
  logic [4:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [SHW:0]       cnt_q, cnt_d;
  logic               ld_q, ld_d;
  logic               sa_q, sa_d;
  logic               sb_q, sb_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic               div0_q, div0_d;
  logic               ill_q, ill_d;

  logic [SHW-1:0]     amt;
  logic [2*WIDTH-1:0] rr, rl;
  logic [WIDTH-1:0]   ex_lo;
  logic               ex_ill;

  assign amt = b_q[SHW-1:0];
  assign rr  = {a_q, a_q} >> amt;
  assign rl  = {a_q, a_q} << amt;

  always_comb begin
    ex_lo  = '0;
    ex_ill = 1'b0;
    case (op_q)
      OP_ADD, OP_ADDI: ex_lo = a_q + b_q;
      OP_SUB:          ex_lo = a_q - b_q;
      OP_SHR:          ex_lo = a_q >> amt;
      OP_SHL:          ex_lo = a_q << amt;
      OP_ROR:          ex_lo = rr[WIDTH-1:0];
      OP_ROL:          ex_lo = rl[2*WIDTH-1:WIDTH];
      OP_AND, OP_ANDI: ex_lo = a_q & b_q;
      OP_OR, OP_ORI:   ex_lo = a_q | b_q;
      OP_NEG:          ex_lo = -a_q;
      OP_NOT:          ex_lo = ~b_q;
      default:         ex_ill = 1'b1;
    endcase
  end

  // Operand magnitudes, taken on the load cycle before iterating.
  logic             sa_n, sb_n;
  logic [WIDTH-1:0] ma, mb;

  assign sa_n = SGN & a_q[WIDTH-1];
  assign sb_n = SGN & b_q[WIDTH-1];
  assign ma   = sa_n ? -a_q : a_q;
  assign mb   = sb_n ? -b_q : b_q;

  logic [WIDTH:0]     msum;
  logic [2*WIDTH-1:0] mul_nx;

  assign msum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                + (acc_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
  assign mul_nx = {msum, acc_q[WIDTH-1:1]};

  logic [WIDTH:0]     rsh, dif;
  logic               qb;
  logic [WIDTH-1:0]   rnx;
  logic [2*WIDTH-1:0] div_nx;

  assign rsh    = acc_q[2*WIDTH-1:WIDTH-1];
  assign dif    = rsh - {1'b0, b_q};
  assign qb     = ~dif[WIDTH];
  assign rnx    = qb ? dif[WIDTH-1:0] : rsh[WIDTH-1:0];
  assign div_nx = {rnx, acc_q[WIDTH-2:0], qb};

  logic [2*WIDTH-1:0] step;
  logic [WIDTH-1:0]   rem, quo;
  logic [2*WIDTH-1:0] mfix, dfix;

  assign step = (state_q == MUL) ? mul_nx : div_nx;
  assign rem  = acc_q[2*WIDTH-1:WIDTH];
  assign quo  = acc_q[WIDTH-1:0];
  assign mfix = (sa_q ^ sb_q) ? -acc_q : acc_q;
  assign dfix = {sa_q ? -rem : rem, (sa_q ^ sb_q) ? -quo : quo};

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ld_d    = ld_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    res_d   = res_q;
    div0_d  = div0_q;
    ill_d   = ill_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d   = bus.opcode;
          a_d    = bus.ra;
          b_d    = bus.rb;
          cnt_d  = '0;
          div0_d = 1'b0;
          ill_d  = 1'b0;
          if (bus.opcode == OP_MUL) begin
            state_d = MUL;
            ld_d    = 1'b1;
          end else if (bus.opcode == OP_DIV && bus.rb != '0) begin
            state_d = DIV;
            ld_d    = 1'b1;
          end else begin
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        done_d  = 1'b1;
        state_d = IDLE;
        // Only a zero-divisor divide ever lands here.
        if (op_q == OP_DIV) begin
          res_d  = {a_q, {WIDTH{1'b1}}};
          div0_d = 1'b1;
        end else begin
          res_d = {{WIDTH{1'b0}}, ex_lo};
          ill_d = ex_ill;
        end
      end
      MUL, DIV: begin
        if (ld_q) begin
          ld_d   = 1'b0;
          busy_d = 1'b1;
          sa_d   = sa_n;
          sb_d   = sb_n;
          if (state_q == MUL) begin
            acc_d = {{WIDTH{1'b0}}, mb};
            b_d   = ma;
          end else begin
            acc_d = {{WIDTH{1'b0}}, ma};
            b_d   = mb;
          end
        end else begin
          acc_d = step;
          cnt_d = cnt_q + ONE;
          if (cnt_q == LAST) begin
            cnt_d = '0;
            if (SGN) begin
              state_d = FIX;
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              res_d   = step;
            end
          end
        end
      end
      FIX: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        res_d   = (op_q == OP_MUL) ? mfix : dfix;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      ld_q    <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
      div0_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ld_q    <= ld_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      res_q   <= res_d;
      div0_q  <= div0_d;
      ill_q   <= ill_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.result  = res_q;
  assign bus.div0    = div0_q;
  assign bus.illegal = ill_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH=32, either build.
// Expected values are hand-computed constants.
module tb_seq_alu;

  localparam int W = 32;

  localparam logic [4:0] ADD = 5'b00011;
  localparam logic [4:0] SUB = 5'b00100;
  localparam logic [4:0] SHR = 5'b00101;
  localparam logic [4:0] SHL = 5'b00110;
  localparam logic [4:0] ROR = 5'b00111;
  localparam logic [4:0] ROL = 5'b01000;
  localparam logic [4:0] ANDI = 5'b01100;
  localparam logic [4:0] MULO = 5'b01110;
  localparam logic [4:0] DIVO = 5'b01111;
  localparam logic [4:0] NEG = 5'b10000;
  localparam logic [4:0] NOTO = 5'b10001;

`ifdef SEQ_ALU_SIGNED_EN
  localparam int LMD = W + 2;
  localparam int BMD = W + 1;
`else
  localparam int LMD = W + 1;
  localparam int BMD = W;
`endif

  logic clk = 1'b0;
  logic clr = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(W)) bus ();

  seq_alu #(.WIDTH(W)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  task automatic do_op(input logic [4:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, output int lat,
                       output int bcnt);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.opcode = op;
    bus.ra     = a;
    bus.rb     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.ra    = '0;
    bus.rb    = '0;
    lat  = 0;
    bcnt = int'(bus.busy);
    while (lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.done) break;
      if (bus.busy) bcnt++;
    end
  endtask

  task automatic test_reset;
    clr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.busy, bus.done, bus.div0, bus.illegal} !== 4'b0) begin
      n_bad++;
      $display("FAIL reset_flags got %b want 0000",
               {bus.busy, bus.done, bus.div0, bus.illegal});
    end
    n_cmp++;
    if (bus.result !== 64'h0) begin
      n_bad++;
      $display("FAIL reset_result got %h want 0", bus.result);
    end
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic test_addsub;
    int lat, bc;
    do_op(ADD, 32'hFFFFFFFF, 32'h2, lat, bc);
    n_cmp++;
    if (lat !== 1 || bc !== 0) begin
      n_bad++;
      $display("FAIL add_lat got %0d/%0d want 1/0", lat, bc);
    end
    n_cmp++;
    if (bus.result !== 64'h00000000_00000001) begin
      n_bad++;
      $display("FAIL add_wrap got %h want 1", bus.result);
    end
    do_op(SUB, 32'h5, 32'h7, lat, bc);
    n_cmp++;
    if (bus.result !== 64'h00000000_FFFFFFFE) begin
      n_bad++;
      $display("FAIL sub_wrap got %h want 00000000FFFFFFFE", bus.result);
    end
  endtask

  task automatic test_logic_shift;
    int lat, bc;
    do_op(ROL, 32'h80000001, 32'd4, lat, bc);
    n_cmp++;
    if (bus.result !== 64'h18) begin
      n_bad++;
      $display("FAIL rol got %h want 18", bus.result);
    end
    do_op(SHR, 32'h80000000, 32'd31, lat, bc);
    n_cmp++;
    if (bus.result !== 64'h1) begin
      n_bad++;
      $display("FAIL shr got %h want 1", bus.result);
    end
    do_op(SHL, 32'hDEADBEEF, 32'd32, lat, bc);
    n_cmp++;
    if (bus.result !== 64'hDEADBEEF) begin
      n_bad++;
      $display("FAIL shl_amt0 got %h want DEADBEEF", bus.result);
    end
    do_op(ROR, 32'h00000003, 32'd1, lat, bc);
    n_cmp++;
    if (bus.result !== 64'h80000001) begin
      n_bad++;
      $display("FAIL ror got %h want 80000001", bus.result);
    end
    do_op(ANDI, 32'hF0F0FFFF, 32'h0FF00F0F, lat, bc);
    n_cmp++;
    if (bus.result !== 64'h00F00F0F) begin
      n_bad++;
      $display("FAIL andi got %h want 00F00F0F", bus.result);
    end
    do_op(NEG, 32'h1, 32'h0, lat, bc);
    n_cmp++;
    if (bus.result !== 64'hFFFFFFFF) begin
      n_bad++;
      $display("FAIL neg got %h want FFFFFFFF", bus.result);
    end
    do_op(NOTO, 32'h0, 32'h0F0F0F0F, lat, bc);
    n_cmp++;
    if (bus.result !== 64'hF0F0F0F0) begin
      n_bad++;
      $display("FAIL not got %h want F0F0F0F0", bus.result);
    end
  endtask

  task automatic test_mul;
    int lat, bc;
    logic [63:0] exp;
`ifdef SEQ_ALU_SIGNED_EN
    exp = 64'hFFFFFFFF_FFFFFFFE;
`else
    exp = 64'h00000001_FFFFFFFE;
`endif
    do_op(MULO, 32'hFFFFFFFF, 32'h2, lat, bc);
    n_cmp++;
    if (lat !== LMD || bc !== BMD) begin
      n_bad++;
      $display("FAIL mul_lat got %0d/%0d want %0d/%0d", lat, bc, LMD, BMD);
    end
    n_cmp++;
    if (bus.result !== exp) begin
      n_bad++;
      $display("FAIL mul got %h want %h", bus.result, exp);
    end
    do_op(MULO, 32'd1234, 32'd5678, lat, bc);
    n_cmp++;
    if (bus.result !== 64'd7006652) begin
      n_bad++;
      $display("FAIL mul_small got %h want %h", bus.result, 64'd7006652);
    end
  endtask

  task automatic test_div;
    int lat, bc;
    logic [63:0] e1, e2;
`ifdef SEQ_ALU_SIGNED_EN
    e1 = 64'hFFFFFFFE_FFFFFFF2;
    e2 = 64'h00000000_80000000;
`else
    e1 = 64'h00000002_24924916;
    e2 = 64'h80000000_00000000;
`endif
    do_op(DIVO, 32'd100, 32'd7, lat, bc);
    n_cmp++;
    if (lat !== LMD) begin
      n_bad++;
      $display("FAIL div_lat got %0d want %0d", lat, LMD);
    end
    n_cmp++;
    if (bus.result !== {32'd2, 32'd14} || bus.div0 !== 1'b0) begin
      n_bad++;
      $display("FAIL div got %h/%b want 000000020000000E/0",
               bus.result, bus.div0);
    end
    do_op(DIVO, 32'hFFFFFF9C, 32'd7, lat, bc);
    n_cmp++;
    if (bus.result !== e1) begin
      n_bad++;
      $display("FAIL div_neg got %h want %h", bus.result, e1);
    end
    do_op(DIVO, 32'h80000000, 32'hFFFFFFFF, lat, bc);
    n_cmp++;
    if (bus.result !== e2) begin
      n_bad++;
      $display("FAIL div_minneg got %h want %h", bus.result, e2);
    end
  endtask

  task automatic test_div0_illegal;
    int lat, bc;
    do_op(DIVO, 32'h00001234, 32'h0, lat, bc);
    n_cmp++;
    if (lat !== 1 || bus.div0 !== 1'b1 || bus.illegal !== 1'b0) begin
      n_bad++;
      $display("FAIL div0_flag got lat=%0d div0=%b ill=%b want 1/1/0",
               lat, bus.div0, bus.illegal);
    end
    n_cmp++;
    if (bus.result !== 64'h00001234_FFFFFFFF) begin
      n_bad++;
      $display("FAIL div0_result got %h want 00001234FFFFFFFF", bus.result);
    end
    do_op(5'b11111, 32'h55, 32'h66, lat, bc);
    n_cmp++;
    if (lat !== 1 || bus.illegal !== 1'b1 || bus.div0 !== 1'b0) begin
      n_bad++;
      $display("FAIL illegal_flag got lat=%0d ill=%b div0=%b want 1/1/0",
               lat, bus.illegal, bus.div0);
    end
    n_cmp++;
    if (bus.result !== 64'h0) begin
      n_bad++;
      $display("FAIL illegal_result got %h want 0", bus.result);
    end
    do_op(ADD, 32'h1, 32'h1, lat, bc);
    n_cmp++;
    if (bus.illegal !== 1'b0 || bus.result !== 64'h2) begin
      n_bad++;
      $display("FAIL illegal_clear got %b/%h want 0/2",
               bus.illegal, bus.result);
    end
  endtask

  task automatic test_start_held;
    int dones = 0;
    int cyc = 0;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.opcode = DIVO;
    bus.ra     = 32'd100;
    bus.rb     = 32'd7;
    @(posedge clk);
    #1;
    bus.ra = 32'h0;
    bus.rb = 32'h0;
    while (cyc < 200 && dones == 0) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.done) begin
        dones++;
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    n_cmp++;
    if (bus.result !== {32'd2, 32'd14}) begin
      n_bad++;
      $display("FAIL held_result got %h want 000000020000000E", bus.result);
    end
    repeat (5) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) dones++;
    end
    n_cmp++;
    if (dones !== 1 || cyc !== LMD) begin
      n_bad++;
      $display("FAIL held_once got %0d dones at %0d want 1 at %0d",
               dones, cyc, LMD);
    end
  endtask

  task automatic test_back_to_back;
    int lat, bc;
    int cyc = 0;
    do_op(ADD, 32'd10, 32'd20, lat, bc);
    bus.start  = 1'b1;
    bus.opcode = SUB;
    bus.ra     = 32'd50;
    bus.rb     = 32'd8;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    while (cyc < 10) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.done) break;
    end
    n_cmp++;
    if (cyc !== 1 || bus.result !== 64'd42) begin
      n_bad++;
      $display("FAIL b2b got cyc=%0d res=%h want 1/2A", cyc, bus.result);
    end
  endtask

  task automatic test_clr_mid;
    int lat, bc;
    int dones = 0;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.opcode = MULO;
    bus.ra     = 32'hFFFFFFFF;
    bus.rb     = 32'h2;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    clr        = 1'b1;
    bus.start  = 1'b1;
    bus.opcode = ADD;
    bus.ra     = 32'd1;
    bus.rb     = 32'd1;
    @(posedge clk);
    #1;
    clr       = 1'b0;
    bus.start = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 64'h0) begin
      n_bad++;
      $display("FAIL clr_state got busy=%b done=%b res=%h want 0/0/0",
               bus.busy, bus.done, bus.result);
    end
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) dones++;
    end
    n_cmp++;
    if (dones !== 0) begin
      n_bad++;
      $display("FAIL clr_nodone got %0d want 0", dones);
    end
    do_op(ADD, 32'd3, 32'd4, lat, bc);
    n_cmp++;
    if (lat !== 1 || bus.result !== 64'd7) begin
      n_bad++;
      $display("FAIL clr_after got lat=%0d res=%h want 1/7", lat, bus.result);
    end
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.opcode = '0;
    bus.ra     = '0;
    bus.rb     = '0;
    test_reset;
    test_addsub;
    test_logic_shift;
    test_mul;
    test_div;
    test_div0_illegal;
    test_start_held;
    test_back_to_back;
    test_clr_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
